// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: word/line widths, arbiter state
// encoding, transaction op code and the default abort timeout.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

  // Cycles a granted transaction may wait for pmem_resp before it is aborted.
  localparam int unsigned ARB_TIMEOUT_CYCLES = 255;

  // Timeout counter width: wide enough for the limit, never narrower than 8.
  function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single physical memory.
// One transaction at a time; the winner's request is latched on the grant
// edge, so requesters may drop or change their inputs mid-grant. A stalled
// transaction is aborted after TIMEOUT_CYCLES grant cycles.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic     clk,
  input  logic     reset_n,
  // I-cache port
  input  logic     i_read,
  input  logic     i_write,
  input  lc3b_word i_address,
  input  lc3b_line i_wdata,
  output logic     i_resp,
  output lc3b_line i_rdata,
  // D-cache port
  input  logic     d_read,
  input  logic     d_write,
  input  lc3b_word d_address,
  input  lc3b_line d_wdata,
  output logic     d_resp,
  output lc3b_line d_rdata,
  // physical memory port
  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp,
  // abort indication
  output logic     timeout_err
);

  localparam int unsigned CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
  // r_count holds the grant cycles already spent waiting, so the abort
  // fires in the TIMEOUT_CYCLES-th grant cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       r_state;
  arb_state_e       w_next;
  logic             r_prio;     // 0: D wins a tie, 1: I wins a tie
  logic [CNT_W-1:0] r_count;
  lc3b_word         r_addr;
  lc3b_line         r_wdata;
  mem_op_e          r_op;

  logic w_i_pend;
  logic w_d_pend;
  logic w_granted;
  logic w_timeout;
  logic w_done;

  assign w_i_pend  = i_read | i_write;
  assign w_d_pend  = d_read | d_write;
  assign w_granted = (r_state != ARB_IDLE);
  // A response arriving in the last allowed cycle completes normally.
  assign w_timeout = w_granted && !pmem_resp && (r_count == CNT_LAST);
  assign w_done    = w_granted && (pmem_resp || w_timeout);

  // State register; reset abandons any transaction in flight.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection and all combinational outputs.
  // NOTE: every output is given a default before the case so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next       = r_state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;
    timeout_err  = w_timeout;

    if (w_granted) begin
      pmem_address = r_addr;
      pmem_wdata   = r_wdata;
      pmem_write   = (r_op == OP_WRITE);
      pmem_read    = (r_op == OP_READ);
    end

    case (r_state)
      ARB_IDLE: begin
        if (w_i_pend && w_d_pend) begin
          w_next = r_prio ? ARB_GRANT_I : ARB_GRANT_D;
        end else if (w_i_pend) begin
          w_next = ARB_GRANT_I;
        end else if (w_d_pend) begin
          w_next = ARB_GRANT_D;
        end
      end
      ARB_GRANT_I: begin
        i_resp  = pmem_resp | w_timeout;
        i_rdata = w_timeout ? '0 : pmem_rdata;
        if (w_done) w_next = ARB_IDLE;
      end
      ARB_GRANT_D: begin
        d_resp  = pmem_resp | w_timeout;
        d_rdata = w_timeout ? '0 : pmem_rdata;
        if (w_done) w_next = ARB_IDLE;
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  // Request latch, timeout counter and round-robin priority bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_op    <= OP_READ;
      r_count <= '0;
      r_prio  <= 1'b0;
    end else begin
      if (r_state == ARB_IDLE) begin
        // Write wins when a requester raises read and write together.
        if (w_next == ARB_GRANT_I) begin
          r_addr  <= i_address;
          r_wdata <= i_wdata;
          r_op    <= i_write ? OP_WRITE : OP_READ;
        end else if (w_next == ARB_GRANT_D) begin
          r_addr  <= d_address;
          r_wdata <= d_wdata;
          r_op    <= d_write ? OP_WRITE : OP_READ;
        end
        r_count <= '0;
      end else if (!w_done) begin
        r_count <= r_count + CNT_W'(1);
      end

      // The requester just served loses the next tie.
      if (w_done) begin
        r_prio <= (r_state == ARB_GRANT_I) ? 1'b0 : 1'b1;
      end
    end
  end

endmodule
